// File: rtl/tqvp_spi_pkg.sv
// Shared definitions for the TinyQV SPI target peripheral:
// register addresses, status bit positions, pin positions and FSM states.
package tqvp_spi_pkg;

    localparam logic [3:0] ADDR_STATUS = 4'd0;
    localparam logic [3:0] ADDR_TXDATA = 4'd1;
    localparam logic [3:0] ADDR_RXDATA = 4'd2;

    localparam int STAT_RX_VALID   = 0;
    localparam int STAT_TX_PENDING = 1;
    localparam int STAT_OVERRUN    = 2;
    localparam int STAT_CS_ACTIVE  = 3;

    localparam int PIN_SCLK = 0;
    localparam int PIN_CS_N = 1;
    localparam int PIN_MOSI = 2;
    localparam int PIN_MISO = 3;

    typedef enum logic [1:0] {
        ST_WAIT_DESEL = 2'd0,
        ST_IDLE       = 2'd1,
        ST_ACTIVE     = 2'd2
    } spi_state_e;

endpackage

// File: rtl/tqvp_sync2.sv
// Two-flop synchronizer for one asynchronous input pin.
// RESET_VAL sets the value both flops take while rst_n is low.
module tqvp_sync2 #(
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_d,
    output logic o_q
);

    logic r_meta;
    logic r_sync;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_meta <= RESET_VAL;
            r_sync <= RESET_VAL;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule

// File: rtl/tqvp_spi_target.sv
// SPI mode-0 target, MSB first, 8-bit frames, exposed to the TinyQV CPU
// through a small byte-wide register file (status, TX byte, RX byte).
module tqvp_spi_target
    import tqvp_spi_pkg::*;
#(
    parameter logic [7:0] TX_DEFAULT = 8'hFF
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] ui_in,
    output logic [7:0] uo_out,
    input  logic [3:0] address,
    input  logic       data_write,
    input  logic [7:0] data_in,
    output logic [7:0] data_out
);

    logic       w_sclk, w_csn, w_mosi;
    logic       r_sclk_d, r_csn_d;
    logic [1:0] r_settle;
    spi_state_e r_state, w_next_state;
    logic [2:0] r_bit_cnt;
    logic [7:0] r_rx_shift, r_tx_shift;
    logic [7:0] r_rx_data, r_tx_data;
    logic       r_rx_valid, r_tx_pending, r_overrun;
    logic       w_unused;

    tqvp_sync2 #(.RESET_VAL(1'b0)) u_sync_sclk (.clk(clk), .rst_n(rst_n), .i_d(ui_in[PIN_SCLK]), .o_q(w_sclk));
    tqvp_sync2 #(.RESET_VAL(1'b1)) u_sync_csn  (.clk(clk), .rst_n(rst_n), .i_d(ui_in[PIN_CS_N]), .o_q(w_csn));
    tqvp_sync2 #(.RESET_VAL(1'b0)) u_sync_mosi (.clk(clk), .rst_n(rst_n), .i_d(ui_in[PIN_MOSI]), .o_q(w_mosi));

    assign w_unused = &{1'b0, ui_in[7:3]};

    logic w_active, w_cs_rise, w_cs_fall, w_sclk_rise, w_sclk_fall;
    logic w_load_idle, w_reload, w_byte_done, w_wr_status, w_wr_tx;
    logic [7:0] w_tx_next;

    // A CS_N rising edge in ACTIVE masks any SCLK edge seen in the same clk.
    assign w_active    = (r_state == ST_ACTIVE);
    assign w_cs_rise   = w_csn & ~r_csn_d;
    assign w_cs_fall   = ~w_csn & r_csn_d;
    assign w_sclk_rise = w_active & ~w_cs_rise & w_sclk & ~r_sclk_d;
    assign w_sclk_fall = w_active & ~w_cs_rise & ~w_sclk & r_sclk_d;
    assign w_load_idle = (r_state == ST_IDLE) & w_cs_fall;
    assign w_reload    = w_load_idle | (w_sclk_fall & (r_bit_cnt == 3'd0));
    assign w_byte_done = w_sclk_rise & (r_bit_cnt == 3'd7);
    assign w_wr_status = data_write & (address == ADDR_STATUS);
    assign w_wr_tx     = data_write & (address == ADDR_TXDATA);
    assign w_tx_next   = r_tx_pending ? r_tx_data : TX_DEFAULT;

    // r_settle keeps WAIT_DESEL from trusting the synchronizer reset value of CS_N.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sclk_d <= 1'b0;
            r_csn_d  <= 1'b1;
            r_settle <= 2'd0;
            r_state  <= ST_WAIT_DESEL;
        end else begin
            r_sclk_d <= w_sclk;
            r_csn_d  <= w_csn;
            if (r_settle != 2'd3) r_settle <= r_settle + 2'd1;
            r_state  <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        unique case (r_state)
            ST_WAIT_DESEL: if (r_settle == 2'd3 && w_csn) w_next_state = ST_IDLE;
            ST_IDLE:       if (w_cs_fall) w_next_state = ST_ACTIVE;
            ST_ACTIVE:     if (w_cs_rise) w_next_state = ST_IDLE;
            default:       w_next_state = ST_WAIT_DESEL;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_bit_cnt  <= 3'd0;
            r_rx_shift <= 8'h00;
            r_tx_shift <= 8'h00;
        end else begin
            if (w_load_idle)      r_bit_cnt <= 3'd0;
            else if (w_sclk_rise) r_bit_cnt <= r_bit_cnt + 3'd1;
            if (w_sclk_rise) r_rx_shift <= {r_rx_shift[6:0], w_mosi};
            if (w_reload)         r_tx_shift <= w_tx_next;
            else if (w_sclk_fall) r_tx_shift <= {r_tx_shift[6:0], 1'b0};
        end
    end

    // Later assignments win: a CPU write re-queues, and a completing byte beats a clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tx_data    <= 8'h00;
            r_tx_pending <= 1'b0;
            r_rx_data    <= 8'h00;
            r_rx_valid   <= 1'b0;
            r_overrun    <= 1'b0;
        end else begin
            if (w_wr_tx) r_tx_data <= data_in;
            if (w_reload) r_tx_pending <= 1'b0;
            if (w_wr_tx)  r_tx_pending <= 1'b1;
            if (w_wr_status && data_in[0]) r_rx_valid <= 1'b0;
            if (w_wr_status && data_in[1]) r_overrun  <= 1'b0;
            if (w_byte_done) begin
                r_rx_data  <= {r_rx_shift[6:0], w_mosi};
                r_rx_valid <= 1'b1;
                if (r_rx_valid) r_overrun <= 1'b1;
            end
        end
    end

    always_comb begin
        uo_out           = 8'h00;
        uo_out[PIN_MISO] = w_active & r_tx_shift[7];
    end

    always_comb begin
        data_out = 8'h00;
        case (address)
            ADDR_STATUS: begin
                data_out[STAT_RX_VALID]   = r_rx_valid;
                data_out[STAT_TX_PENDING] = r_tx_pending;
                data_out[STAT_OVERRUN]    = r_overrun;
                data_out[STAT_CS_ACTIVE]  = w_active;
            end
            ADDR_TXDATA: data_out = r_tx_data;
            ADDR_RXDATA: data_out = r_rx_data;
            default:     data_out = 8'h00;
        endcase
    end

endmodule
